// File: rtl/sprite_scheduler.sv
// rtl/sprite_scheduler.sv - sprite table walker feeding the frame-buffer renderer
// One pass per frame_count change; each active entry is handed over with a one-cycle sprite_valid pulse.
module sprite_scheduler #(
    parameter int MAX_SPRITES   = 16,
    parameter int NUM_FRAMES    = 18,
    parameter int CANVAS_WIDTH  = 360,
    parameter int CANVAS_HEIGHT = 720,
    parameter int ANIM_DIV      = 4,
    parameter int MAX_ANIM_LEN  = 8,
    localparam int IW = $clog2(MAX_SPRITES),
    localparam int XW = $clog2(CANVAS_WIDTH),
    localparam int YW = $clog2(CANVAS_HEIGHT),
    localparam int FW = $clog2(NUM_FRAMES),
    localparam int LW = $clog2(MAX_ANIM_LEN) + 1,
    localparam int DW = $clog2(MAX_SPRITES) + 1,
    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
) (
    input  logic          clk_pixel,
    input  logic          sys_rst,
    input  logic [5:0]    frame_count,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_index,
    input  logic          wr_active,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  logic [FW-1:0] wr_base_frame,
    input  logic [LW-1:0] wr_anim_len,
    input  logic          sprite_ready,
    output logic          sprite_valid,
    output logic [XW-1:0] sprite_x,
    output logic [YW-1:0] sprite_y,
    output logic [FW-1:0] sprite_frame_number,
    output logic          pass_busy,
    output logic [DW-1:0] sprites_drawn,
    output logic          overrun
);
    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_DONE
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_SPRITES - 1);

    logic [MAX_SPRITES-1:0] active_q;
    logic [XW-1:0] x_q     [MAX_SPRITES];
    logic [YW-1:0] y_q     [MAX_SPRITES];
    logic [FW-1:0] base_q  [MAX_SPRITES];
    logic [LW-1:0] len_q   [MAX_SPRITES];
    logic [LW-1:0] phase_q [MAX_SPRITES];

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [DW-1:0] drawn_q;
    logic          restart_q;
    logic [5:0]    prev_fc_q;
    logic [AW-1:0] anim_cnt_q;
    logic          anim_tick_q;
    logic          valid_q;
    logic [XW-1:0] out_x_q;
    logic [YW-1:0] out_y_q;
    logic [FW-1:0] out_f_q;
    logic          busy_q;
    logic [DW-1:0] sprites_drawn_q;
    logic          overrun_q;

    logic          frame_start;
    logic          phase_adv;
    logic [LW-1:0] cur_phase, cur_len, phase_d;
    logic [FW:0]   fsum;
    logic [FW-1:0] fnum_d;

    assign frame_start = (frame_count != prev_fc_q);
    assign phase_adv   = (state_q == S_ISSUE) && sprite_ready && anim_tick_q && !frame_start;

    // Sum is one bit wider so base+phase past the last sheet frame clamps instead of wrapping.
    always_comb begin
        cur_phase = phase_q[idx_q];
        cur_len   = (len_q[idx_q] == '0) ? LW'(1) : len_q[idx_q];
        phase_d   = (cur_phase >= cur_len - LW'(1)) ? '0 : cur_phase + LW'(1);
        fsum      = (FW+1)'(base_q[idx_q]) + (FW+1)'(cur_phase);
        fnum_d    = (fsum >= (FW+1)'(NUM_FRAMES)) ? FW'(NUM_FRAMES - 1) : fsum[FW-1:0];
    end

    always_ff @(posedge clk_pixel) begin
        if (sys_rst) begin
            active_q <= '0;
            for (int i = 0; i < MAX_SPRITES; i++) begin
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                base_q[i]  <= '0;
                len_q[i]   <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            if (phase_adv) phase_q[idx_q] <= phase_d;
            if (wr_en) begin
                active_q[wr_index] <= wr_active;
                x_q[wr_index]      <= wr_x;
                y_q[wr_index]      <= wr_y;
                base_q[wr_index]   <= wr_base_frame;
                len_q[wr_index]    <= wr_anim_len;
                phase_q[wr_index]  <= '0;
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (sys_rst) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            drawn_q         <= '0;
            restart_q       <= 1'b0;
            prev_fc_q       <= frame_count;
            anim_cnt_q      <= '0;
            anim_tick_q     <= 1'b0;
            valid_q         <= 1'b0;
            out_x_q         <= '0;
            out_y_q         <= '0;
            out_f_q         <= '0;
            busy_q          <= 1'b0;
            sprites_drawn_q <= '0;
            overrun_q       <= 1'b0;
        end else begin
            prev_fc_q <= frame_count;
            valid_q   <= 1'b0;
            if (frame_start) begin
                idx_q   <= '0;
                drawn_q <= '0;
                busy_q  <= 1'b1;
                if (anim_cnt_q == AW'(ANIM_DIV - 1)) begin
                    anim_cnt_q  <= '0;
                    anim_tick_q <= 1'b1;
                end else begin
                    anim_cnt_q  <= anim_cnt_q + AW'(1);
                    anim_tick_q <= 1'b0;
                end
                if (state_q != S_IDLE) begin
                    overrun_q       <= 1'b1;
                    sprites_drawn_q <= drawn_q;
                end
                // Mid-handshake restarts finish the renderer exchange before rescanning from 0.
                if (state_q == S_WAIT_ACK || state_q == S_WAIT_DONE) restart_q <= 1'b1;
                else                                                 state_q   <= S_SCAN;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_SCAN: begin
                        if (active_q[idx_q])      state_q <= S_ISSUE;
                        else if (idx_q == LAST_IDX) state_q <= S_DONE;
                        else                      idx_q   <= idx_q + IW'(1);
                    end
                    S_ISSUE: begin
                        if (sprite_ready) begin
                            valid_q <= 1'b1;
                            out_x_q <= x_q[idx_q];
                            out_y_q <= y_q[idx_q];
                            out_f_q <= fnum_d;
                            drawn_q <= drawn_q + DW'(1);
                            state_q <= S_WAIT_ACK;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (!sprite_ready) state_q <= S_WAIT_DONE;
                    end
                    S_WAIT_DONE: begin
                        if (sprite_ready) begin
                            if (restart_q) begin
                                restart_q <= 1'b0;
                                state_q   <= S_SCAN;
                            end else if (idx_q == LAST_IDX) begin
                                state_q <= S_DONE;
                            end else begin
                                idx_q   <= idx_q + IW'(1);
                                state_q <= S_SCAN;
                            end
                        end
                    end
                    S_DONE: begin
                        sprites_drawn_q <= drawn_q;
                        busy_q          <= 1'b0;
                        state_q         <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign sprite_valid        = valid_q;
    assign sprite_x            = out_x_q;
    assign sprite_y            = out_y_q;
    assign sprite_frame_number = out_f_q;
    assign pass_busy           = busy_q;
    assign sprites_drawn       = sprites_drawn_q;
    assign overrun             = overrun_q;
endmodule

// File: tb/tb_sprite_scheduler.sv
// tb/tb_sprite_scheduler.sv - directed bench for sprite_scheduler
// Renderer model acknowledges each pulse by dropping ready for busy_cycles cycles.
module tb_sprite_scheduler;
    logic       clk_pixel = 1'b0;
    logic       sys_rst   = 1'b1;
    logic [5:0] frame_count = 6'd0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_index = '0;
    logic       wr_active = 1'b0;
    logic [8:0] wr_x = '0;
    logic [9:0] wr_y = '0;
    logic [4:0] wr_base_frame = '0;
    logic [3:0] wr_anim_len = '0;
    logic       sprite_ready;
    logic       sprite_valid;
    logic [8:0] sprite_x;
    logic [9:0] sprite_y;
    logic [4:0] sprite_frame_number;
    logic       pass_busy;
    logic [4:0] sprites_drawn;
    logic       overrun;

    sprite_scheduler dut (
        .clk_pixel(clk_pixel), .sys_rst(sys_rst), .frame_count(frame_count),
        .wr_en(wr_en), .wr_index(wr_index), .wr_active(wr_active), .wr_x(wr_x), .wr_y(wr_y),
        .wr_base_frame(wr_base_frame), .wr_anim_len(wr_anim_len), .sprite_ready(sprite_ready),
        .sprite_valid(sprite_valid), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_frame_number(sprite_frame_number), .pass_busy(pass_busy),
        .sprites_drawn(sprites_drawn), .overrun(overrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cycles = 2;
    int busy_left = 0;
    bit hold_ready = 1'b0;
    int pulses = 0;
    int proto_err = 0;
    bit prev_v = 1'b0;
    int px[$];
    int py[$];
    int pf[$];
    int exp_anim[13] = '{6, 6, 6, 6, 7, 7, 7, 7, 8, 8, 8, 8, 6};

    initial begin
        sprite_ready = 1'b1;
        forever begin
            @(negedge clk_pixel);
            if (sprite_valid && (prev_v || !sprite_ready)) proto_err++;
            prev_v = sprite_valid;
            if (sprite_valid) begin
                pulses++;
                px.push_back(int'(sprite_x));
                py.push_back(int'(sprite_y));
                pf.push_back(int'(sprite_frame_number));
                busy_left = busy_cycles;
            end
            if (busy_left > 0) begin
                sprite_ready = 1'b0;
                busy_left--;
            end else begin
                sprite_ready = !hold_ready;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_log();
        pulses = 0;
        px.delete();
        py.delete();
        pf.delete();
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        wr_en = 1'b0;
        hold_ready = 1'b0;
        busy_left = 0;
        @(posedge clk_pixel); #1;
        frame_count = frame_count + 6'd7;
        repeat (2) @(posedge clk_pixel);
        #1 sys_rst = 1'b0;
        clear_log();
    endtask

    task automatic write_entry(input int idx, input bit act, input int x, input int y,
                               input int base, input int len);
        wr_en = 1'b1;
        wr_index = 4'(idx);
        wr_active = act;
        wr_x = 9'(x);
        wr_y = 10'(y);
        wr_base_frame = 5'(base);
        wr_anim_len = 4'(len);
        @(posedge clk_pixel); #1;
        wr_en = 1'b0;
    endtask

    task automatic bump();
        frame_count = frame_count + 6'd1;
    endtask

    task automatic wait_pass(input string tag, input int budget);
        int n;
        n = 0;
        @(posedge clk_pixel); #1;
        while (pass_busy && n < budget) begin
            @(posedge clk_pixel); #1;
            n++;
        end
        check(tag, pass_busy, 0);
    endtask

    initial begin
        int n;
        do_reset();
        check("rst_valid", sprite_valid, 0);
        check("rst_busy", pass_busy, 0);
        check("rst_drawn", sprites_drawn, 0);
        check("rst_overrun", overrun, 0);
        check("rst_x", sprite_x, 0);
        repeat (5) @(posedge clk_pixel);
        #1;
        check("rst_no_pass", pass_busy, 0);
        check("rst_no_pulse", pulses, 0);

        // two sprites, slow renderer
        write_entry(0, 1, 10, 20, 2, 1);
        write_entry(3, 1, 100, 200, 5, 1);
        busy_cycles = 64;
        clear_log();
        bump();
        wait_pass("t1_done", 2000);
        check("t1_pulses", pulses, 2);
        check("t1_x0", qget(px, 0), 10);
        check("t1_y0", qget(py, 0), 20);
        check("t1_f0", qget(pf, 0), 2);
        check("t1_x1", qget(px, 1), 100);
        check("t1_y1", qget(py, 1), 200);
        check("t1_f1", qget(pf, 1), 5);
        check("t1_drawn", sprites_drawn, 2);
        check("t1_overrun", overrun, 0);
        check("t1_hold_x", sprite_x, 100);

        // animation stepping every ANIM_DIV frames
        do_reset();
        busy_cycles = 2;
        write_entry(0, 1, 1, 1, 6, 3);
        for (int f = 0; f < 13; f++) begin
            clear_log();
            bump();
            wait_pass("t2_done", 200);
            check($sformatf("t2_frame%0d", f), qget(pf, 0), exp_anim[f]);
        end

        // frame number clamp
        do_reset();
        write_entry(0, 1, 5, 5, 17, 4);
        for (int f = 0; f < 8; f++) begin
            clear_log();
            bump();
            wait_pass("t3_done", 200);
            check($sformatf("t3_clamp%0d", f), qget(pf, 0), 17);
        end

        // ready held low at pass start
        do_reset();
        write_entry(1, 1, 33, 44, 0, 1);
        hold_ready = 1'b1;
        @(posedge clk_pixel); #1;
        clear_log();
        bump();
        repeat (100) @(posedge clk_pixel);
        #1;
        check("t5_no_pulse", pulses, 0);
        check("t5_busy", pass_busy, 1);
        hold_ready = 1'b0;
        repeat (2) @(posedge clk_pixel);
        #1;
        check("t5_pulse", pulses, 1);
        check("t5_x", qget(px, 0), 33);
        wait_pass("t5_done", 200);

        // write colliding with the issue cycle of the same entry
        do_reset();
        write_entry(2, 1, 40, 1, 0, 1);
        clear_log();
        bump();
        repeat (4) @(posedge clk_pixel);
        #1;
        write_entry(2, 1, 50, 1, 0, 1);
        wait_pass("t6_done", 200);
        check("t6_pulses", pulses, 1);
        check("t6_old_x", qget(px, 0), 40);
        clear_log();
        bump();
        wait_pass("t6_done2", 200);
        check("t6_new_x", qget(px, 0), 50);

        // overrun: frame advances while renderer is busy on the fifth sprite
        do_reset();
        for (int i = 0; i < 16; i++) write_entry(i, 1, i * 10 + 1, i, 0, 1);
        busy_cycles = 4096;
        clear_log();
        bump();
        n = 0;
        while (pulses < 5 && n < 25000) begin
            @(posedge clk_pixel); #1;
            n++;
        end
        check("t4_five", pulses, 5);
        bump();
        repeat (2) @(posedge clk_pixel);
        #1;
        check("t4_overrun", overrun, 1);
        check("t4_drawn", sprites_drawn, 5);
        n = 0;
        while (!sprite_ready && n < 5000) begin
            @(posedge clk_pixel); #1;
            n++;
        end
        check("t4_ready_back", sprite_ready, 1);
        check("t4_no_early", pulses, 5);
        n = 0;
        while (pulses < 6 && n < 20) begin
            @(posedge clk_pixel); #1;
            n++;
        end
        check("t4_sixth", pulses, 6);
        check("t4_restart_x", qget(px, 5), 1);
        sys_rst = 1'b1;
        @(posedge clk_pixel); #1;
        check("t4_rst_valid", sprite_valid, 0);
        check("t4_rst_busy", pass_busy, 0);
        check("t4_rst_overrun", overrun, 0);
        sys_rst = 1'b0;
        busy_left = 0;

        check("protocol", proto_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
